ram_fifo_ctrl: RTL
==================

# ram_fifo_ctrl

FIFO controller sitting directly upstream of the 4096×16 single-port RAM (`RAM4096_16bit`). It converts a push/pop handshake into RAM `read`/`write`/`en1`/`add` cycles using wrapping 12-bit pointers, and tracks occupancy and full/empty. An optional post-reset sweep zero-fills the RAM before traffic is accepted.

## Interface
Parameters:
- `AW`, 12: RAM address width; depth = 2^AW.
- `DW`, 16: data width.
- `AFULL_TH`, 4032: `almost_full` asserts when `count >= AFULL_TH`.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the RAM after reset; 0 = go straight to RUN.

Ports:
- `clk`  in  1: single clock, rising edge. One clock; reset is asynchronous and active-high.
- `rst`  in  1: asynchronous, active-high reset.
- `push_valid`  in  1: write request.
- `push_data`  in  DW: write data.
- `push_ready`  out  1: push accepted on this edge when `push_valid & push_ready`.
- `pop_req`  in  1: read request.
- `pop_ready`  out  1: pop accepted on this edge when `pop_req & pop_ready`.
- `dout`  out  DW: pop data (`ram_out` passthrough).
- `dout_valid`  out  1: `dout` valid in this cycle.
- `count`  out  AW+1: occupancy, 0..2^AW.
- `empty`, `full`, `almost_full`  out  1 each: status flags.
- `init_done`  out  1: high once the clear sweep is finished (or immediately if `CLEAR_ON_RESET=0`).
- `ram_add`  out  AW: RAM address.
- `ram_in`  out  DW: RAM write data.
- `ram_read`, `ram_write`, `ram_en1`  out  1 each: RAM controls.
- `ram_out`  in  DW: RAM read data.

## Operation
- FSM states:
  - **INIT**: entered on reset when `CLEAR_ON_RESET=1`. Each cycle drives `ram_en1=1`, `ram_write=1`, `ram_read=1`, `ram_in=0`, `ram_add=clr_ptr`, then increments `clr_ptr`. After address 2^AW−1 is written, the FSM goes to RUN.
  - **RUN**: normal operation. When `CLEAR_ON_RESET=0`, reset enters RUN directly.
- RAM command encoding:
  - Write: `en1=1`, `write=1`, `read=1`.
  - Read: `en1=1`, `write=0`, `read=1`.
  - Idle: all three 0.
- Single port, so at most one RAM operation per cycle.
- `pop_ready = RUN & !empty`.
- `push_ready = RUN & !full & !(pop_req & !empty)`. Pop has priority; a simultaneous push stalls one cycle.
- Accepted push:
  - `ram_add = wr_ptr`, `ram_in = push_data`, write command.
  - `wr_ptr` increments mod 2^AW; `count` increments.
- Accepted pop:
  - `ram_add = rd_ptr`, read command.
  - `rd_ptr` increments mod 2^AW; `count` decrements.
  - `dout_valid` is high the next cycle.
- RAM controls are combinational from the accept conditions. `ram_add`/`ram_in` hold 0 when idle.
- `empty = (count==0)`, `full = (count==2^AW)`. Pointer equality alone is never used.
- Pointer wrap-around: 4095 → 0, with no effect on `count`.
- Push while full, or pop while empty, is ignored: no RAM access, no state change.

## Timing
- Reset values:
  - FSM = INIT (or RUN); `clr_ptr = wr_ptr = rd_ptr = 0`; `count = 0`.
  - `empty=1`, `full=0`, `almost_full=0`, `dout_valid=0`, `init_done=0` (1 if `CLEAR_ON_RESET=0`).
  - `push_ready = pop_ready = 0` during reset and INIT.
  - `ram_en1 = ram_write = ram_read = 0` while `rst` is high.
- INIT lasts exactly 2^AW cycles after `rst` falls. `init_done` rises on the edge that completes address 4095. The first push can be accepted in the following cycle.
- Write latency: data is in the RAM at the accepting edge.
- Read latency: the pop is accepted at edge N. `dout_valid=1` and `dout` = entry during cycle N+1. Back-to-back pops give one word per cycle.
- Flags and `count` update on the accepting edge and are registered.
- Reset asserted mid-operation: all state clears immediately, the FIFO contents are logically discarded, and INIT reruns.

## Test plan
- **Reset/clear:** assert `rst`, release, then wait.
  - Required: `init_done` rises after exactly 4096 cycles.
  - Required: a raw read of addresses 2, 514, 1026 … 3586 returns 0.
- **Basic order:** push 2, 514, 1026, …, 3586 (8 words), then pop 8 times.
  - Required: `dout` returns the same values in order, each with `dout_valid` one cycle after its pop.
  - Required: `count` goes 8 → 0 and `empty=1` at the end.
- **Full:** push 4096 words.
  - Required: `full=1`, `count=4096`, `push_ready=0`.
  - Required: a 4097th push causes no RAM write.
  - Required: `almost_full` rises at `count=4032`.
- **Wrap-around:** push 4000, pop 4000, push 200 values 0x0100+k.
  - Required: `wr_ptr` wraps to 104.
  - Required: pops return 0x0100 … 0x01C7 in order.
- **Simultaneous:** with `count=5`, assert `push_valid` and `pop_req` in the same cycle.
  - Required: the pop is accepted and `push_ready=0`.
  - Required: the push is accepted next cycle; `count` goes 5 → 4 → 5.
- **Reset mid-run:** with `count=10`, assert `rst` for one cycle.
  - Required: `count=0`, `empty=1`, `dout_valid=0` immediately.
  - Required: INIT reruns for 4096 cycles.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//   Push/pop handshake and status bundle between a FIFO client and
//   ram_fifo_ctrl.
//   master : client side (drives push_valid/push_data/pop_req)
//   slave  : controller side (drives readiness, pop data and status)
//   Signals: push_valid, push_data[DW], push_ready, pop_req, pop_ready,
//            dout[DW], dout_valid, count[AW+1], empty, full,
//            almost_full, init_done
interface ram_fifo_ctrl_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic          push_valid;
   logic [DW-1:0] push_data;
   logic          push_ready;
   logic          pop_req;
   logic          pop_ready;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          init_done;

   modport master (
      output push_valid, push_data, pop_req,
      input  push_ready, pop_ready, dout, dout_valid, count,
             empty, full, almost_full, init_done
   );

   modport slave (
      input  push_valid, push_data, pop_req,
      output push_ready, pop_ready, dout, dout_valid, count,
             empty, full, almost_full, init_done
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller in front of a single-port 2^AW x DW RAM. Turns the
//   push/pop handshake into RAM read/write cycles using wrapping pointers,
//   tracks occupancy and flags, and optionally zero-fills the RAM after
//   reset before accepting traffic.
//   clk, rst   : clock, asynchronous active-high reset
//   fifo       : push/pop handshake and status (slave side)
//   ram_add    : RAM address          ram_in    : RAM write data
//   ram_read, ram_write, ram_en1      : RAM command (write = 1/1/1,
//                                       read = en1+read, idle = all 0)
//   ram_out    : RAM read data, passed through to fifo.dout
module ram_fifo_ctrl #(
   parameter int AW             = 12,
   parameter int DW             = 16,
   parameter int AFULL_TH       = 4032,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic           clk,
   input  logic           rst,
   ram_fifo_ctrl_if.slave fifo,
   output logic [AW-1:0]  ram_add,
   output logic [DW-1:0]  ram_in,
   output logic           ram_read,
   output logic           ram_write,
   output logic           ram_en1,
   input  logic [DW-1:0]  ram_out
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam state_t      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
   localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_TH);

   state_t        state, state_nx;
   logic [AW-1:0] clr_ptr, wr_ptr, rd_ptr;
   logic [AW:0]   count_r;
   logic          dout_valid_r;
   logic          run, not_empty, not_full, pop_acc, push_acc;

   // Acceptance and RAM command decode; gating with rst keeps the RAM idle
   // while reset is held even though the state register already sits in INIT.
   always_comb begin
      run       = (state == ST_RUN) && !rst;
      not_empty = (count_r != '0);
      not_full  = (count_r != DEPTH_CNT);
      pop_acc   = run && fifo.pop_req && not_empty;
      // Pop owns the single RAM port; a coincident push waits a cycle.
      push_acc  = run && fifo.push_valid && not_full && !(fifo.pop_req && not_empty);

      state_nx  = state;
      ram_en1   = 1'b0;
      ram_write = 1'b0;
      ram_read  = 1'b0;
      ram_add   = '0;
      ram_in    = '0;

      case (state)
         ST_INIT: begin
            if (!rst) begin
               ram_en1   = 1'b1;
               ram_write = 1'b1;
               ram_read  = 1'b1;
               ram_add   = clr_ptr;
            end
            if (clr_ptr == '1) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (pop_acc) begin
               ram_en1  = 1'b1;
               ram_read = 1'b1;
               ram_add  = rd_ptr;
            end else if (push_acc) begin
               ram_en1   = 1'b1;
               ram_write = 1'b1;
               ram_read  = 1'b1;
               ram_add   = wr_ptr;
               ram_in    = fifo.push_data;
            end
         end
         default: state_nx = RST_STATE;
      endcase
   end

   always_comb begin
      fifo.push_ready  = run && not_full && !(fifo.pop_req && not_empty);
      fifo.pop_ready   = run && not_empty;
      fifo.dout        = ram_out;
      fifo.dout_valid  = dout_valid_r;
      fifo.count       = count_r;
      fifo.empty       = !not_empty;
      fifo.full        = !not_full;
      fifo.almost_full = (count_r >= AFULL_CNT);
      fifo.init_done   = (state == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RST_STATE;
         clr_ptr      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_r      <= '0;
         dout_valid_r <= 1'b0;
      end else begin
         state        <= state_nx;
         dout_valid_r <= pop_acc;
         if (state == ST_INIT) clr_ptr <= clr_ptr + AW'(1);
         if (push_acc) begin
            wr_ptr  <= wr_ptr + AW'(1);
            count_r <= count_r + (AW+1)'(1);
         end else if (pop_acc) begin
            rd_ptr  <= rd_ptr + AW'(1);
            count_r <= count_r - (AW+1)'(1);
         end
      end
   end

endmodule
